// File: rtl/cfg_pkg.sv
// ---------------------------------------------------------------------------
// cfg_pkg
// Shared definitions for the fx-bus configuration register bank.
//   FX_ADDR_W  : full fx address width (device id + byte address)
//   FX_DEV_LSB : lowest bit of the device id field
//   FX_DEV_W   : width of the device id field
//   FX_BYTE_W  : width of the byte address field
// Helper functions split an fx address into device hit, register index and
// byte lane for a given register width in bytes.
// ---------------------------------------------------------------------------
package cfg_pkg;

   localparam int FX_ADDR_W  = 22;
   localparam int FX_DEV_LSB = 16;
   localparam int FX_DEV_W   = 6;
   localparam int FX_BYTE_W  = 16;

   // True when the device id field of the address matches this board.
   function automatic logic dev_hit(input logic [FX_ADDR_W-1:0] addr,
                                    input logic [FX_DEV_W-1:0]  dev);
      return addr[FX_DEV_LSB +: FX_DEV_W] == dev;
   endfunction

   // Byte address field of an fx address.
   function automatic logic [FX_BYTE_W-1:0] byte_addr(input logic [FX_ADDR_W-1:0] addr);
      return addr[FX_BYTE_W-1:0];
   endfunction

   // Register index: byte address divided by the register width in bytes.
   function automatic logic [FX_BYTE_W-1:0] reg_index(input logic [FX_BYTE_W-1:0] baddr,
                                                      input int unsigned          reg_bytes);
      return baddr / FX_BYTE_W'(reg_bytes);
   endfunction

   // Byte lane within the register; register widths never exceed 8 bytes.
   function automatic logic [2:0] byte_lane(input logic [FX_BYTE_W-1:0] baddr,
                                            input int unsigned          reg_bytes);
      return 3'(baddr % FX_BYTE_W'(reg_bytes));
   endfunction

endpackage

// File: rtl/cfg_rd_snap.sv
// ---------------------------------------------------------------------------
// cfg_rd_snap
// Read side of the register bank. A lane-0 read captures the whole register
// into a snapshot so that the remaining lanes of a multi-byte read come from
// one coherent value even if the source changes in between.
// Ports:
//   clk_sys, rst_n : clock, asynchronous active-low reset
//   rd_en          : fx read strobe (one byte per high cycle)
//   rd_sel         : strobe addresses this device and an existing register
//   rd_idx         : register index of the read
//   rd_lane        : byte lane of the read
//   rd_value       : current full value of the indexed register
//   fx_q           : registered read byte, held until the next strobe
// ---------------------------------------------------------------------------
module cfg_rd_snap
   import cfg_pkg::*;
#(
   parameter int REG_BYTES = 4
) (
   input  logic                   clk_sys,
   input  logic                   rst_n,
   input  logic                   rd_en,
   input  logic                   rd_sel,
   input  logic [FX_BYTE_W-1:0]   rd_idx,
   input  logic [2:0]             rd_lane,
   input  logic [REG_BYTES*8-1:0] rd_value,
   output logic [7:0]             fx_q
);

   logic [REG_BYTES*8-1:0] snap;
   logic [FX_BYTE_W-1:0]   snap_idx;

   // A miss returns zero so several boards can share the bus by wired-OR.
   // Upper lanes only come from the snapshot when they belong to the same
   // register that the last lane-0 read captured; otherwise they read zero.
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         snap     <= '0;
         snap_idx <= '0;
         fx_q     <= '0;
      end else if (rd_en) begin
         if (!rd_sel) begin
            fx_q <= '0;
         end else if (rd_lane == 3'd0) begin
            snap     <= rd_value;
            snap_idx <= rd_idx;
            fx_q     <= rd_value[7:0];
         end else if (rd_idx == snap_idx) begin
            fx_q <= snap[rd_lane*8 +: 8];
         end else begin
            fx_q <= '0;
         end
      end
   end

endmodule

// File: rtl/cfg_regbank.sv
// ---------------------------------------------------------------------------
// cfg_regbank
// NREG writable configuration registers plus NSTAT read-only status
// registers on the fx bus, each REG_BYTES wide. Lower lanes of a write go
// into one shared staging buffer; writing the top lane commits the whole
// register at once and pulses its cfg_upd bit for one cycle.
// Optional build macro: CFG_REG_SELFCLR_EN -- bits of register 0 set in
// SELFCLR_MASK clear themselves one cycle after the commit that set them.
// Ports:
//   clk_sys, rst_n     : clock, asynchronous active-low reset
//   dev_id             : device id of this board
//   fx_waddr/wr/data   : write address, strobe, data byte
//   fx_raddr/rd        : read address, strobe
//   fx_q               : registered read byte
//   stat_in            : status register values, register k at slice k
//   cfg_out            : committed configuration values
//   cfg_upd            : one-cycle commit pulse per register
// ---------------------------------------------------------------------------
module cfg_regbank
   import cfg_pkg::*;
#(
   parameter int                   NREG         = 16,
   parameter int                   NSTAT        = 4,
   parameter int                   REG_BYTES    = 4,
   parameter logic [REG_BYTES*8-1:0] SELFCLR_MASK = '0
) (
   input  logic                         clk_sys,
   input  logic                         rst_n,
   input  logic [FX_DEV_W-1:0]          dev_id,
   input  logic [FX_ADDR_W-1:0]         fx_waddr,
   input  logic                         fx_wr,
   input  logic [7:0]                   fx_data,
   input  logic [FX_ADDR_W-1:0]         fx_raddr,
   input  logic                         fx_rd,
   output logic [7:0]                   fx_q,
   input  logic [NSTAT*REG_BYTES*8-1:0] stat_in,
   output logic [NREG*REG_BYTES*8-1:0]  cfg_out,
   output logic [NREG-1:0]              cfg_upd
);

   localparam int RW = REG_BYTES * 8;
   localparam int SW = (REG_BYTES > 1) ? (REG_BYTES - 1) * 8 : 8;

   // With the feature off the mask is forced to zero, so the clear path
   // below never changes anything and every bit holds until rewritten.
`ifdef CFG_REG_SELFCLR_EN
   localparam logic [RW-1:0] CLR_MASK = SELFCLR_MASK;
`else
   localparam logic [RW-1:0] CLR_MASK = SELFCLR_MASK & '0;
`endif

   logic [FX_BYTE_W-1:0] w_idx;
   logic [2:0]           w_lane;
   logic                 w_cfg;
   logic                 w_commit;
   logic [SW-1:0]        staging;
   logic [RW-1:0]        commit_val;

   logic [FX_BYTE_W-1:0] r_idx;
   logic [2:0]           r_lane;
   logic                 r_sel;
   logic [RW-1:0]        r_value;

   assign w_idx    = reg_index(byte_addr(fx_waddr), REG_BYTES);
   assign w_lane   = byte_lane(byte_addr(fx_waddr), REG_BYTES);
   assign w_cfg    = fx_wr && dev_hit(fx_waddr, dev_id) && (w_idx < FX_BYTE_W'(NREG));
   assign w_commit = w_cfg && (w_lane == 3'(REG_BYTES - 1));

   // Single-byte registers have no staging; every write commits directly.
   generate
      if (REG_BYTES == 1) begin : g_commit_narrow
         assign commit_val = fx_data;
      end else begin : g_commit_wide
         assign commit_val = {fx_data, staging};
      end
   endgenerate

   // Write side: staging fills from lower lanes and is never cleared by a
   // commit, so a later top-lane-only write reuses the last staged bytes.
   // The commit assignment comes after the self-clear so that a back-to-back
   // commit to register 0 takes its new value rather than being cleared.
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         cfg_out <= '0;
         cfg_upd <= '0;
         staging <= '0;
      end else begin
         cfg_upd <= '0;
         if (cfg_upd[0]) begin
            cfg_out[RW-1:0] <= cfg_out[RW-1:0] & ~CLR_MASK;
         end
         if (w_cfg && (w_lane < 3'(REG_BYTES - 1))) begin
            staging[w_lane*8 +: 8] <= fx_data;
         end
         for (int r = 0; r < NREG; r++) begin
            if (w_commit && (w_idx == FX_BYTE_W'(r))) begin
               cfg_out[r*RW +: RW] <= commit_val;
               cfg_upd[r]          <= 1'b1;
            end
         end
      end
   end

   assign r_idx  = reg_index(byte_addr(fx_raddr), REG_BYTES);
   assign r_lane = byte_lane(byte_addr(fx_raddr), REG_BYTES);
   assign r_sel  = dev_hit(fx_raddr, dev_id) && (r_idx < FX_BYTE_W'(NREG + NSTAT));

   // Current value of the register being read: config registers first, then
   // status registers; the pre-edge cfg_out gives pre-commit data on a
   // same-cycle write and read.
   always_comb begin
      r_value = '0;
      for (int r = 0; r < NREG; r++) begin
         if (r_idx == FX_BYTE_W'(r)) begin
            r_value = cfg_out[r*RW +: RW];
         end
      end
      for (int s = 0; s < NSTAT; s++) begin
         if (r_idx == FX_BYTE_W'(NREG + s)) begin
            r_value = stat_in[s*RW +: RW];
         end
      end
   end

   cfg_rd_snap #(
      .REG_BYTES (REG_BYTES)
   ) u_rd_snap (
      .clk_sys  (clk_sys),
      .rst_n    (rst_n),
      .rd_en    (fx_rd),
      .rd_sel   (r_sel),
      .rd_idx   (r_idx),
      .rd_lane  (r_lane),
      .rd_value (r_value),
      .fx_q     (fx_q)
   );

endmodule

// File: tb/tb_cfg_regbank.sv
// ---------------------------------------------------------------------------
// tb_cfg_regbank
// Directed bench for cfg_regbank with default parameters (16 config regs,
// 4 status regs, 4-byte registers) and SELFCLR_MASK = 1. Build with
// CFG_REG_SELFCLR_EN defined to exercise the self-clearing variant.
// ---------------------------------------------------------------------------
module tb_cfg_regbank;

   logic         clk_sys = 1'b0;
   logic         rst_n;
   logic [5:0]   dev_id;
   logic [21:0]  fx_waddr;
   logic         fx_wr;
   logic [7:0]   fx_data;
   logic [21:0]  fx_raddr;
   logic         fx_rd;
   logic [7:0]   fx_q;
   logic [127:0] stat_in;
   logic [511:0] cfg_out;
   logic [15:0]  cfg_upd;

   int tests_run    = 0;
   int tests_failed = 0;

   cfg_regbank #(
      .NREG         (16),
      .NSTAT        (4),
      .REG_BYTES    (4),
      .SELFCLR_MASK (32'h0000_0001)
   ) dut (
      .clk_sys  (clk_sys),
      .rst_n    (rst_n),
      .dev_id   (dev_id),
      .fx_waddr (fx_waddr),
      .fx_wr    (fx_wr),
      .fx_data  (fx_data),
      .fx_raddr (fx_raddr),
      .fx_rd    (fx_rd),
      .fx_q     (fx_q),
      .stat_in  (stat_in),
      .cfg_out  (cfg_out),
      .cfg_upd  (cfg_upd)
   );

   // Free-running 100 MHz system clock.
   always #5 clk_sys = ~clk_sys;

   // Advance one clock and settle just after the edge, where inputs are
   // driven and outputs are sampled.
   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   function automatic logic [31:0] cfg_reg(input int idx);
      return cfg_out[idx*32 +: 32];
   endfunction

   // One comparison: count it, and on a difference count and report it.
   task automatic check_output(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
      tests_run++;
      assert (observed === expected)
      else begin
         tests_failed++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // One-cycle write strobe of a single byte.
   task automatic write_byte(input logic [5:0] dev, input logic [15:0] addr,
                             input logic [7:0] data);
      fx_waddr = {dev, addr};
      fx_data  = data;
      fx_wr    = 1'b1;
      tick();
      fx_wr    = 1'b0;
   endtask

   // One-cycle read strobe; fx_q is valid on return.
   task automatic read_byte(input logic [5:0] dev, input logic [15:0] addr);
      fx_raddr = {dev, addr};
      fx_rd    = 1'b1;
      tick();
      fx_rd    = 1'b0;
   endtask

   // Directed sequence: reset, commit, miss, status snapshot, same-cycle
   // write/read, staging reuse, mid-sequence reset, register 0 self-clear.
   initial begin
      rst_n    = 1'b0;
      dev_id   = 6'd5;
      fx_waddr = '0;
      fx_wr    = 1'b0;
      fx_data  = '0;
      fx_raddr = '0;
      fx_rd    = 1'b0;
      stat_in  = '0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      check_output("reset_cfg_out", 64'(cfg_out != '0), 64'd0);
      check_output("reset_cfg_upd", 64'(cfg_upd), 64'h0);
      check_output("reset_fx_q", 64'(fx_q), 64'h0);

      $display("[TB] step 1: four-byte commit to register 2");
      write_byte(6'd5, 16'h0008, 8'h11);
      write_byte(6'd5, 16'h0009, 8'h22);
      write_byte(6'd5, 16'h000A, 8'h33);
      check_output("t1_no_early_commit", 64'(cfg_reg(2)), 64'h0);
      check_output("t1_no_early_upd", 64'(cfg_upd), 64'h0);
      write_byte(6'd5, 16'h000B, 8'h44);
      check_output("t1_commit_value", 64'(cfg_reg(2)), 64'h4433_2211);
      check_output("t1_upd_pulse", 64'(cfg_upd), 64'h0004);
      tick();
      check_output("t1_upd_one_cycle", 64'(cfg_upd), 64'h0000);

      $display("[TB] step 2: other device id is ignored");
      write_byte(6'd6, 16'h000B, 8'h77);
      check_output("t2_miss_write", 64'(cfg_reg(2)), 64'h4433_2211);
      check_output("t2_miss_no_upd", 64'(cfg_upd), 64'h0);
      read_byte(6'd5, 16'h0008);
      check_output("t2_hit_read", 64'(fx_q), 64'h11);
      read_byte(6'd6, 16'h0000);
      check_output("t2_miss_read", 64'(fx_q), 64'h00);

      $display("[TB] step 3: status snapshot coherence");
      stat_in[31:0] = 32'hA1B2_C3D4;
      read_byte(6'd5, 16'h0040);
      check_output("t3_stat_lane0", 64'(fx_q), 64'hD4);
      stat_in[31:0] = 32'h0000_0000;
      read_byte(6'd5, 16'h0041);
      check_output("t3_stat_lane1", 64'(fx_q), 64'hC3);
      read_byte(6'd5, 16'h0042);
      check_output("t3_stat_lane2", 64'(fx_q), 64'hB2);
      read_byte(6'd5, 16'h0043);
      check_output("t3_stat_lane3", 64'(fx_q), 64'hA1);
      read_byte(6'd5, 16'h0009);
      check_output("t3_other_idx_lane", 64'(fx_q), 64'h00);
      read_byte(6'd5, 16'h0042);
      check_output("t3_snapshot_kept", 64'(fx_q), 64'hB2);
      read_byte(6'd5, 16'h0050);
      check_output("t3_out_of_range", 64'(fx_q), 64'h00);

      $display("[TB] step 4: same-cycle commit and read on register 3");
      write_byte(6'd5, 16'h000C, 8'h88);
      write_byte(6'd5, 16'h000D, 8'h77);
      write_byte(6'd5, 16'h000E, 8'h66);
      read_byte(6'd5, 16'h0008);
      check_output("t4_prior_read", 64'(fx_q), 64'h11);
      fx_waddr = {6'd5, 16'h000F};
      fx_data  = 8'h55;
      fx_wr    = 1'b1;
      fx_raddr = {6'd5, 16'h000C};
      fx_rd    = 1'b1;
      tick();
      fx_wr    = 1'b0;
      fx_rd    = 1'b0;
      check_output("t4_pre_commit_read", 64'(fx_q), 64'h00);
      check_output("t4_commit_value", 64'(cfg_reg(3)), 64'h5566_7788);
      read_byte(6'd5, 16'h000C);
      check_output("t4_post_commit_read", 64'(fx_q), 64'h88);
      read_byte(6'd5, 16'h000F);
      check_output("t4_lane3_read", 64'(fx_q), 64'h55);
      write_byte(6'd5, 16'h0013, 8'hAB);
      check_output("t4_staging_reuse", 64'(cfg_reg(4)), 64'hAB66_7788);

      $display("[TB] step 5: reset in the middle of a register write");
      write_byte(6'd5, 16'h0014, 8'h01);
      write_byte(6'd5, 16'h0015, 8'h02);
      rst_n = 1'b0;
      #2;
      check_output("t5_async_clear", 64'(cfg_out != '0), 64'd0);
      check_output("t5_no_upd", 64'(cfg_upd), 64'h0);
      tick();
      rst_n = 1'b1;
      tick();
      write_byte(6'd5, 16'h0017, 8'h99);
      check_output("t5_staging_dropped", 64'(cfg_reg(5)), 64'h9900_0000);
      check_output("t5_upd_reg5", 64'(cfg_upd), 64'h0020);

      $display("[TB] step 6: register 0 command bits");
      write_byte(6'd5, 16'h0000, 8'h03);
      write_byte(6'd5, 16'h0001, 8'h00);
      write_byte(6'd5, 16'h0002, 8'h00);
      write_byte(6'd5, 16'h0003, 8'h00);
      check_output("t6_commit_value", 64'(cfg_reg(0)), 64'h0000_0003);
      tick();
`ifdef CFG_REG_SELFCLR_EN
      check_output("t6_bit0_cleared", 64'(cfg_reg(0)), 64'h0000_0002);
      read_byte(6'd5, 16'h0000);
      check_output("t6_read_post_clear", 64'(fx_q), 64'h02);
`else
      check_output("t6_bits_hold", 64'(cfg_reg(0)), 64'h0000_0003);
      read_byte(6'd5, 16'h0000);
      check_output("t6_read_held", 64'(fx_q), 64'h03);
`endif

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/cfg_regbank.md
Name: cfg_regbank

Overview:
- Parametrised successor to the single-instance configuration register block on the fx bus.
- Provides NREG writable configuration registers plus NSTAT read-only status registers, each REG_BYTES wide.
- Multi-byte writes are staged and committed atomically; multi-byte reads are snapshot-coherent.
- Sits under control_top, fed by the fx bus; drives configuration outputs to datapath blocks in the clk_sys domain.

Parameters:
- NREG, 16, number of writable config registers (1..64)
- NSTAT, 4, number of read-only status registers (0..64)
- REG_BYTES, 4, bytes per register (1..8)
- SELFCLR_MASK, all zeros, self-clearing bit mask for register 0 (used only with the optional feature)

Ports:
- clk_sys  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- dev_id  in  6  device id of this board
- fx_waddr  in  22  write address: [21:16] device id, [15:0] byte address
- fx_wr  in  1  write strobe, one byte per high cycle
- fx_data  in  8  write data
- fx_raddr  in  22  read address, same format as fx_waddr
- fx_rd  in  1  read strobe, one byte per high cycle
- fx_q  out  8  registered read data
- stat_in  in  NSTAT*REG_BYTES*8  status values, register k at slice k
- cfg_out  out  NREG*REG_BYTES*8  committed config values
- cfg_upd  out  NREG  one-cycle pulse per register on commit

Behaviour:
- Reset: cfg_out=0, cfg_upd=0, fx_q=0, staging=0, read snapshot=0.
- Hit: addr[21:16]==dev_id. Register index = byte_addr / REG_BYTES; lane = byte_addr % REG_BYTES.
  - Indices 0..NREG-1 are config registers.
  - Indices NREG..NREG+NSTAT-1 are status registers.
  - Higher indices are out of range.
- Write, fx_wr && hit && index<NREG:
  - lane < REG_BYTES-1: fx_data goes into staging[lane] only. Staging is a single shared buffer.
  - lane == REG_BYTES-1: commit. cfg_out[index] = {fx_data, staging[REG_BYTES-2:0]} on the next edge; cfg_upd[index]=1 for exactly that one cycle.
  - Staging is not cleared by a commit; unwritten lanes keep their last staged value.
  - REG_BYTES==1: every write commits.
- Writes ignored: miss, status index, out-of-range index.
- Read, fx_rd && hit: fx_q is valid 1 cycle after the strobe, held until the next fx_rd.
  - lane 0: snapshot <= full current value (cfg_out or stat_in); fx_q <= byte 0 of that value.
  - lane>0: fx_q <= snapshot[lane].
- fx_q = 0 on read:
  - miss (allows wired-OR across devices)
  - out-of-range index
  - lane>0 read of a different index than the snapshot source
- Same-cycle fx_wr and fx_rd on the same register: read returns the pre-commit value.
- Reset mid-sequence: partial staging is discarded; no cfg_upd is issued.
- No back-pressure: one byte per cycle sustained on both ports.

Optional Feature:
- Macro CFG_REG_SELFCLR_EN.
- Defined: bits of cfg_out[0] set in SELFCLR_MASK clear automatically one cycle after the commit that set them, so each command bit is a one-cycle pulse. Reads return the post-clear value. Other bits and registers are unaffected.
- Undefined: all bits hold until rewritten; SELFCLR_MASK is ignored.

Decomposition:
- Package cfg_pkg:
  - FX_ADDR_W=22, FX_DEV_LSB=16, FX_DEV_W=6, FX_BYTE_W=16
  - byte-lane and index extraction functions
- Sub-module cfg_rd_snap: read-side snapshot and lane mux producing fx_q. The write/commit logic stays in cfg_regbank.

Test Plan:
1. dev_id=5, REG_BYTES=4. Write bytes 11,22,33,44 to addr {5,0x0008} to {5,0x000B} -> cfg_out[2]=0x44332211 after the 4th write; cfg_upd[2] high exactly 1 cycle; cfg_out[2] unchanged after the first 3 writes.
2. Write to {6,0x0008} with dev_id=5 -> no change. Read {6,0x0000} -> fx_q=0.
3. stat_in[0]=0xA1B2C3D4, NREG=16. Read addr 0x40..0x43 -> D4,C3,B2,A1. Change stat_in after the 0x40 read -> bytes 0x41..0x43 still from the snapshot.
4. Same-cycle fx_wr commit and fx_rd lane0 on register 3 (old 0, new 0x55667788) -> fx_q=0x00; the next lane0 read returns 0x88.
5. Assert rst_n low after 2 of 4 byte writes, release, write only lane 3 = 0x99 -> cfg_out=0x99000000.
6. With CFG_REG_SELFCLR_EN and SELFCLR_MASK=0x1: commit 0x00000003 to reg 0 -> bit0 high 1 cycle then 0; bit1 stays 1.
